// File: rtl/param_shift_register.sv
// ---------------------------------------------------------------------------
// param_shift_register
//   Universal shift register of DEPTH stages, WIDTH bits each. Supports hold,
//   shift right, shift left and parallel load, and keeps a saturating count
//   of how many stages hold valid data. Serves as a serial/parallel converter
//   and as a datapath delay line.
//
//   Optional feature macro: ROTATE_EN
//     When defined, the rot input exists. A shift with rot=1 recirculates the
//     exiting stage into the entering stage instead of taking d. A rotate
//     leaves the fill count unchanged.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (overrides en/mode)
//   en         in   update enable; 0 holds all state
//   mode       in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d          in   serial input word
//   load_data  in   parallel load word, stage i = [i*WIDTH +: WIDTH]
//   rot        in   recirculate select (ROTATE_EN builds only)
//   q          out  all stages, same packing as load_data
//   sout       out  word shifted out on the last shift (registered)
//   count      out  valid-stage count, saturates at DEPTH
//   full       out  count == DEPTH
// ---------------------------------------------------------------------------
module param_shift_register #(
    parameter int unsigned  WIDTH = 1,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic [DEPTH*WIDTH-1:0]   load_data,
`ifdef ROTATE_EN
    input  logic                     rot,
`endif
    output logic [DEPTH*WIDTH-1:0]   q,
    output logic [WIDTH-1:0]         sout,
    output logic [CNT_W-1:0]         count,
    output logic                     full
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    mode_e                   mode_s;
    logic                    rot_active;
    logic [WIDTH-1:0]        exit_r;
    logic [WIDTH-1:0]        exit_l;
    logic [WIDTH-1:0]        enter_r;
    logic [WIDTH-1:0]        enter_l;
    logic [CNT_W-1:0]        count_inc;

    logic [DEPTH*WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]        sout_q, sout_d;
    logic [CNT_W-1:0]        count_q, count_d;

    assign mode_s = mode_e'(mode);

`ifdef ROTATE_EN
    assign rot_active = rot;
`else
    assign rot_active = 1'b0;
`endif

    // Exiting word for each direction: top stage for right, stage 0 for left.
    assign exit_r  = data_q[DEPTH*WIDTH-1 -: WIDTH];
    assign exit_l  = data_q[WIDTH-1:0];
    assign enter_r = rot_active ? exit_r : d;
    assign enter_l = rot_active ? exit_l : d;

    // Saturating increment; a rotate does not add new data.
    assign count_inc = (rot_active || (count_q == CNT_MAX)) ? count_q
                                                            : count_q + CNT_W'(1);

    always_comb begin
        data_d  = data_q;
        sout_d  = sout_q;
        count_d = count_q;
        if (en) begin
            case (mode_s)
                MODE_SHR: begin
                    // Stage i takes stage i-1: the packed vector moves up by WIDTH.
                    data_d  = {data_q[(DEPTH-1)*WIDTH-1:0], enter_r};
                    sout_d  = exit_r;
                    count_d = count_inc;
                end
                MODE_SHL: begin
                    // Stage i takes stage i+1: the packed vector moves down by WIDTH.
                    data_d  = {enter_l, data_q[DEPTH*WIDTH-1:WIDTH]};
                    sout_d  = exit_l;
                    count_d = count_inc;
                end
                MODE_LOAD: begin
                    data_d  = load_data;
                    count_d = CNT_MAX;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sout_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            sout_q  <= sout_d;
            count_q <= count_d;
        end
    end

    assign q     = data_q;
    assign sout  = sout_q;
    assign count = count_q;
    assign full  = (count_q == CNT_MAX);

endmodule

// File: tb/tb_param_shift_register.sv
// ---------------------------------------------------------------------------
// tb_param_shift_register
//   Directed bench for param_shift_register. Instance u_dut uses the default
//   WIDTH=1/DEPTH=4; instance u_dut_w uses WIDTH=2/DEPTH=3 to exercise word
//   packing. Rotate vectors are built only when ROTATE_EN is defined.
// ---------------------------------------------------------------------------
module tb_param_shift_register;

    localparam int unsigned CW_A = $clog2(4 + 1);
    localparam int unsigned CW_B = $clog2(3 + 1);

    logic            clk;
    int unsigned     n_checks;
    int unsigned     n_errors;

    // Instance A: WIDTH=1, DEPTH=4
    logic            rst, en;
    logic [1:0]      mode;
    logic [0:0]      d;
    logic [3:0]      load_data;
    logic            rot;
    logic [3:0]      q;
    logic [0:0]      sout;
    logic [CW_A-1:0] count;
    logic            full;

    // Instance B: WIDTH=2, DEPTH=3
    logic            rst_b, en_b;
    logic [1:0]      mode_b;
    logic [1:0]      d_b;
    logic [5:0]      load_b;
    logic            rot_b;
    logic [5:0]      q_b;
    logic [1:0]      sout_b;
    logic [CW_B-1:0] count_b;
    logic            full_b;

    param_shift_register #(.WIDTH(1), .DEPTH(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .load_data (load_data),
`ifdef ROTATE_EN
        .rot       (rot),
`endif
        .q         (q),
        .sout      (sout),
        .count     (count),
        .full      (full)
    );

    param_shift_register #(.WIDTH(2), .DEPTH(3)) u_dut_w (
        .clk       (clk),
        .rst       (rst_b),
        .en        (en_b),
        .mode      (mode_b),
        .d         (d_b),
        .load_data (load_b),
`ifdef ROTATE_EN
        .rot       (rot_b),
`endif
        .q         (q_b),
        .sout      (sout_b),
        .count     (count_b),
        .full      (full_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs of instance A at once.
    task automatic chk_a(input string tag, input logic [3:0] eq, input logic es,
                         input logic [CW_A-1:0] ec, input logic ef);
        check_eq({tag, ".q"},     64'(q),     64'(eq));
        check_eq({tag, ".sout"},  64'(sout),  64'(es));
        check_eq({tag, ".count"}, 64'(count), 64'(ec));
        check_eq({tag, ".full"},  64'(full),  64'(ef));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst = 1'b1; en = 1'b0; mode = 2'b00; d = 1'b0; load_data = '0; rot = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 2'b00; d_b = '0; load_b = '0; rot_b = 1'b0;

        // Reset held for two edges
        tick();
        tick();
        chk_a("reset", 4'b0000, 1'b0, 0, 1'b0);
        check_eq("b_reset.q", 64'(q_b), 64'd0);
        check_eq("b_reset.count", 64'(count_b), 64'd0);
        rst_b = 1'b0;

        // Fill by shifting right 1,0,1,1; stage 0 is q[0]
        rst = 1'b0; en = 1'b1; mode = 2'b01;
        d = 1'b1; tick(); chk_a("shr1", 4'b0001, 1'b0, 1, 1'b0);
        d = 1'b0; tick(); chk_a("shr2", 4'b0010, 1'b0, 2, 1'b0);
        d = 1'b1; tick(); chk_a("shr3", 4'b0101, 1'b0, 3, 1'b0);
        d = 1'b1; tick(); chk_a("shr4", 4'b1011, 1'b0, 4, 1'b1);

        // Keep shifting with d = 0,0,1,1; sout replays the entry order
        d = 1'b0; tick(); chk_a("shr5", 4'b0110, 1'b1, 4, 1'b1);
        d = 1'b0; tick(); chk_a("shr6", 4'b1100, 1'b0, 4, 1'b1);
        d = 1'b1; tick(); chk_a("shr7", 4'b1001, 1'b1, 4, 1'b1);
        d = 1'b1; tick(); chk_a("shr8", 4'b0011, 1'b1, 4, 1'b1);

        // Direction change keeps count and reverses through the same stages
        mode = 2'b10; d = 1'b1; tick(); chk_a("dirchg", 4'b1001, 1'b1, 4, 1'b1);

        // Parallel load: sout holds its last shifted value
        mode = 2'b11; load_data = 4'b1010; tick(); chk_a("load", 4'b1010, 1'b1, 4, 1'b1);

        // Shift left three times with d=0
        mode = 2'b10; d = 1'b0;
        tick(); chk_a("shl1", 4'b0101, 1'b0, 4, 1'b1);
        tick(); chk_a("shl2", 4'b0010, 1'b1, 4, 1'b1);
        tick(); chk_a("shl3", 4'b0001, 1'b0, 4, 1'b1);

        // en=0 holds everything despite mode=01
        en = 1'b0; mode = 2'b01; d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a("en_hold", 4'b0001, 1'b0, 4, 1'b1);
        end

        // mode=00 holds with en=1
        en = 1'b1; mode = 2'b00; tick(); chk_a("mode_hold", 4'b0001, 1'b0, 4, 1'b1);

        // Reset during a shift discards everything at that edge
        mode = 2'b01; d = 1'b1; rst = 1'b1; tick(); chk_a("rst_mid", 4'b0000, 1'b0, 0, 1'b0);
        rst = 1'b0; tick(); chk_a("post_rst", 4'b0001, 1'b0, 1, 1'b0);

        // Load forces count to DEPTH from a partial fill
        mode = 2'b11; load_data = 4'b0110; tick(); chk_a("load_cnt", 4'b0110, 1'b0, 4, 1'b1);

`ifdef ROTATE_EN
        // Rotate right of 0001: the exiting top stage re-enters stage 0
        load_data = 4'b0001; tick();
        mode = 2'b01; rot = 1'b1; d = 1'b0;
        tick(); chk_a("rotr1", 4'b0010, 1'b0, 4, 1'b1);
        tick(); chk_a("rotr2", 4'b0100, 1'b0, 4, 1'b1);
        tick(); chk_a("rotr3", 4'b1000, 1'b0, 4, 1'b1);
        tick(); chk_a("rotr4", 4'b0001, 1'b1, 4, 1'b1);
        // Rotate left: stage 0 exits and re-enters at the top
        mode = 2'b10; tick(); chk_a("rotl", 4'b1000, 1'b1, 4, 1'b1);
        // Rotate ignores d and does not advance count
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b01; d = 1'b1; tick(); chk_a("rot_cnt", 4'b0000, 1'b0, 0, 1'b0);
        rot = 1'b0;
`endif
        en = 1'b0;

        // Instance B: stage i = q_b[2i+1:2i], q_b = {s2,s1,s0}
        en_b = 1'b1; mode_b = 2'b01;
        d_b = 2'b01; tick();
        check_eq("b_shr1.q", 64'(q_b), 64'(6'b000001));
        check_eq("b_shr1.count", 64'(count_b), 64'd1);
        d_b = 2'b10; tick();
        check_eq("b_shr2.q", 64'(q_b), 64'(6'b000110));
        d_b = 2'b11; tick();
        check_eq("b_shr3.q", 64'(q_b), 64'(6'b011011));
        check_eq("b_shr3.count", 64'(count_b), 64'd3);
        check_eq("b_shr3.full", 64'(full_b), 64'd1);
        d_b = 2'b00; tick();
        check_eq("b_shr4.q", 64'(q_b), 64'(6'b101100));
        check_eq("b_shr4.sout", 64'(sout_b), 64'(2'b01));
        check_eq("b_shr4.count", 64'(count_b), 64'd3);
        mode_b = 2'b11; load_b = 6'b111000; tick();
        check_eq("b_load.q", 64'(q_b), 64'(6'b111000));
        check_eq("b_load.sout", 64'(sout_b), 64'(2'b01));
        mode_b = 2'b10; d_b = 2'b01; tick();
        check_eq("b_shl.q", 64'(q_b), 64'(6'b011110));
        check_eq("b_shl.sout", 64'(sout_b), 64'(2'b00));
        en_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
